// File: rtl/mem_bus_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_bridge_if
// Description : MEM-side RAM request and external data bus signals of the
//               MEM-to-bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_bridge_if;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic        stall_req;
    logic        bus_err;
    logic        bus_req;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    // The bridge drives the bus; the pipeline and bus memory form the slave side.
    modport master (
        input  ram_en, ram_write_en, ram_addr, ram_write_data, bus_ack, bus_rdata,
        output ram_read_data, stall_req, bus_err, bus_req, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output ram_en, ram_write_en, ram_addr, ram_write_data, bus_ack, bus_rdata,
        input  ram_read_data, stall_req, bus_err, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_bridge
// Description : Turns MEM's single-cycle RAM request into a req/ack bus
//               transaction, stalling the pipeline until ack or timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_bridge_if.master  bus
);

    localparam int C_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
    localparam bit C_TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic               bus_req_q,   bus_req_d;
    logic [3:0]         bus_we_q,    bus_we_d;
    logic [31:0]        bus_addr_q,  bus_addr_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;
    logic [31:0]        rdata_q,     rdata_d;
    logic               err_q,       err_d;
    logic [C_CNT_W-1:0] cnt_q,       cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 4'd0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.ram_en) begin
                    bus_addr_d  = bus.ram_addr;
                    bus_we_d    = bus.ram_write_en;
                    bus_wdata_d = bus.ram_write_data;
                    bus_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack wins over a timeout landing on the same cycle.
                if (bus.bus_ack) begin
                    if (bus_we_q == 4'd0) begin
                        rdata_d = bus.bus_rdata;
                    end
                    bus_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (C_TIMEOUT_EN && (cnt_q == C_CNT_LAST)) begin
                    if (bus_we_q == 4'd0) begin
                        rdata_d = 32'd0;
                    end
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_DONE: begin
                // ram_en is still high here for the finished access; do not re-issue.
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    assign bus.stall_req     = (state_q == ST_REQ) || ((state_q == ST_IDLE) && bus.ram_en);
    assign bus.bus_req       = bus_req_q;
    assign bus.bus_we        = bus_we_q;
    assign bus.bus_addr      = bus_addr_q;
    assign bus.bus_wdata     = bus_wdata_q;
    assign bus.ram_read_data = rdata_q;
    assign bus.bus_err       = err_q;

endmodule
`default_nettype wire
